// File: rtl/vga_pkg.sv
// Shared VGA timing descriptors and the sync/blank payload carried through the scan-out pipeline.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_1440x900_60 = '{
        h_active: 32'd1440, h_fp: 32'd80, h_sync: 32'd152, h_bp: 32'd232,
        v_active: 32'd900,  v_fp: 32'd1,  v_sync: 32'd3,   v_bp: 32'd28,
        hs_pol: 1'b0, vs_pol: 1'b1
    };

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96, h_bp: 32'd48,
        v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,  v_bp: 32'd33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    // Active-true flags; all-zero is the idle/blank value.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register aligning {hs, vs, de} with the pixel fetch latency.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  sync_t d,
    output sync_t q
);

    sync_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// Parametrised VGA raster engine: fetch coordinates ahead of the beam, latency-aligned
// sync/RGB outputs, and front/back buffer swaps restricted to the start of vblank.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_1440x900_60.h_active,
    parameter int unsigned H_FP     = VGA_1440x900_60.h_fp,
    parameter int unsigned H_SYNC   = VGA_1440x900_60.h_sync,
    parameter int unsigned H_BP     = VGA_1440x900_60.h_bp,
    parameter int unsigned V_ACTIVE = VGA_1440x900_60.v_active,
    parameter int unsigned V_FP     = VGA_1440x900_60.v_fp,
    parameter int unsigned V_SYNC   = VGA_1440x900_60.v_sync,
    parameter int unsigned V_BP     = VGA_1440x900_60.v_bp,
    parameter logic        HS_POL   = VGA_1440x900_60.hs_pol,
    parameter logic        VS_POL   = VGA_1440x900_60.vs_pol,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned RD_LAT   = 2,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL),
    localparam int unsigned RGB_W   = 3 * COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [HW-1:0]      fetch_x,
    output logic [VW-1:0]      fetch_y,
    output logic               fetch_valid,
    input  logic [RGB_W-1:0]   pix_rgb,
    output logic               front_sel,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_start,
    output logic               vblank,
    output logic [15:0]        frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          swap_now;
    sync_t         raw;
    sync_t         dly;

    assign h_last = (32'(h) == H_TOTAL - 1);
    assign v_last = (32'(v) == V_TOTAL - 1);

    // Raster counters; disabling parks the beam at (0,0) so re-enable starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign fetch_x     = h;
    assign fetch_y     = v;
    assign fetch_valid = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    assign vblank      = (32'(v) >= V_ACTIVE);
    assign frame_start = en && (h == '0) && (v == '0);
    assign swap_now    = en && swap_req && (h == '0) && (32'(v) == V_ACTIVE);

    assign raw.hs = (32'(h) >= HS_START) && (32'(h) < HS_END);
    assign raw.vs = (32'(v) >= VS_START) && (32'(v) < VS_END);
    assign raw.de = fetch_valid;

    vga_sync_delay #(
        .DEPTH (RD_LAT)
    ) u_sync_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (!en),
        .d     (raw),
        .q     (dly)
    );

    // Pin stage: forced inactive on the same edge scan is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (!en) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hsync <= dly.hs ? HS_POL : ~HS_POL;
            vsync <= dly.vs ? VS_POL : ~VS_POL;
            red   <= dly.de ? pix_rgb[RGB_W-1 -: COLOR_W]     : '0;
            green <= dly.de ? pix_rgb[2*COLOR_W-1 -: COLOR_W] : '0;
            blue  <= dly.de ? pix_rgb[COLOR_W-1:0]            : '0;
        end
    end

    // Buffer swap and frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_count <= '0;
        end else begin
            front_sel   <= front_sel ^ swap_now;
            swap_ack    <= swap_now;
            frame_count <= frame_count + 16'(frame_start);
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed plus randomized bench for vga_scanout on a 14x7 raster with a 2-cycle fetch latency.
module tb_vga_scanout;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam int HA = 8;
    localparam int VA = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        swap_req = 1'b0;
    logic [11:0] pix_rgb = '0;
    logic [3:0]  fetch_x;
    logic [2:0]  fetch_y;
    logic        fetch_valid, front_sel, swap_ack, frame_start, vblank, hsync, vsync;
    logic [15:0] frame_count;
    logic [3:0]  red, green, blue;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(4), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
        .pix_rgb(pix_rgb), .front_sel(front_sel), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .vblank(vblank), .frame_count(frame_count),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: linear pixel index within the frame plus a 3-deep history of fetches.
    int          m_pos = 0;
    logic        m_front = 1'b0;
    logic        m_ack = 1'b0;
    logic [15:0] m_fc = '0;
    logic        h_en[3];
    int          h_x[3];
    int          h_y[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_front = 1'b0; m_ack = 1'b0; m_fc = '0;
        for (int i = 0; i < 3; i++) begin
            h_en[i] = 1'b0; h_x[i] = 0; h_y[i] = 0;
        end
    endtask

    // Called at posedge+1: asserts reset, checks the asynchronous reset state, releases after two edges.
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; swap_req = 1'b0;
        #1;
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_front", 32'(front_sel), 32'd0);
        check("rst_ack", 32'(swap_ack), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One pixel clock: check pin-side state, apply inputs, check fetch side, advance the model.
    task automatic cycle(input logic en_v, input logic req_v);
        logic act, e_de;
        int   ox, oy, x, y;
        logic fs_exp, sw;
        act  = h_en[0] && h_en[1] && h_en[2];
        ox   = h_x[2];
        oy   = h_y[2];
        e_de = act && ox < HA && oy < VA;
        check("hsync", 32'(hsync), 32'(!(act && ox >= 10 && ox < 12)));
        check("vsync", 32'(vsync), 32'(act && oy >= 5 && oy < 6));
        check("red", 32'(red), e_de ? 32'(ox) : 32'd0);
        check("green", 32'(green), e_de ? 32'(oy) : 32'd0);
        check("blue", 32'(blue), e_de ? 32'd10 : 32'd0);
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("swap_ack", 32'(swap_ack), 32'(m_ack));
        check("frame_count", 32'(frame_count), 32'(m_fc));

        en = en_v;
        swap_req = req_v;
        pix_rgb = {4'(h_x[1]), 4'(h_y[1]), 4'hA};
        #1;
        x = m_pos % HT;
        y = m_pos / HT;
        fs_exp = en_v && m_pos == 0;
        check("fetch_x", 32'(fetch_x), 32'(x));
        check("fetch_y", 32'(fetch_y), 32'(y));
        check("fetch_valid", 32'(fetch_valid), 32'(x < HA && y < VA));
        check("vblank", 32'(vblank), 32'(y >= VA));
        check("frame_start", 32'(frame_start), 32'(fs_exp));

        sw = en_v && req_v && x == 0 && y == VA;
        m_front = m_front ^ sw;
        m_ack = sw;
        if (fs_exp) m_fc = m_fc + 16'd1;
        h_en[2] = h_en[1]; h_x[2] = h_x[1]; h_y[2] = h_y[1];
        h_en[1] = h_en[0]; h_x[1] = h_x[0]; h_y[1] = h_y[0];
        h_en[0] = en_v;    h_x[0] = x;      h_y[0] = y;
        m_pos = en_v ? (m_pos + 1) % FT : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int tx, input int ty, input logic en_v, input logic req_v);
        int n;
        n = 0;
        while (m_pos != tx + ty * HT && n < 300) begin
            cycle(en_v, req_v);
            n++;
        end
        check("run_to_x", 32'(fetch_x), 32'(tx));
        check("run_to_y", 32'(fetch_y), 32'(ty));
    endtask

    initial begin
        int lows, vhi, t10, tlow, acks;
        logic r;
        model_reset();
        #2;
        do_reset();

        // Reset release: first enabled cycle is (0,0) with frame_start.
        cycle(1'b1, 1'b0);
        run_to(0, 0, 1'b1, 1'b0);

        // One full frame of sync timing.
        lows = 0; vhi = 0; t10 = -1; tlow = -1;
        for (int i = 0; i < FT; i++) begin
            if (m_pos == 10 && t10 < 0) t10 = i;
            if (hsync == 1'b0 && t10 >= 0 && tlow < 0) tlow = i;
            if (hsync == 1'b0) lows++;
            if (vsync == 1'b1) vhi++;
            cycle(1'b1, 1'b0);
        end
        check("hsync_low_per_frame", 32'(lows), 32'd14);
        check("vsync_high_per_frame", 32'(vhi), 32'd14);
        check("hsync_latency", 32'(tlow - t10), 32'd3);

        // Pixel (5,2) reaches the pins three cycles after its fetch.
        run_to(5, 2, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        check("pix_5_2", 32'({red, green, blue}), 32'h52A);

        // Swap request raised mid-frame, held across two vblanks.
        run_to(3, 1, 1'b1, 1'b0);
        run_to(0, 4, 1'b1, 1'b1);
        check("pre_swap_front", 32'(front_sel), 32'd0);
        cycle(1'b1, 1'b1);
        check("swap_ack_pulse", 32'(swap_ack), 32'd1);
        check("swap_front", 32'(front_sel), 32'd1);
        acks = 0;
        for (int i = 0; i < FT; i++) begin
            cycle(1'b1, 1'b1);
            if (swap_ack) acks++;
        end
        check("acks_per_frame", 32'(acks), 32'd1);
        check("swap_back_front", 32'(front_sel), 32'd0);
        cycle(1'b1, 1'b0);

        // Enable dropped mid-line for five cycles.
        run_to(6, 2, 1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("dis_rgb", 32'({red, green, blue}), 32'd0);
        check("dis_hsync", 32'(hsync), 32'd1);
        repeat (4) cycle(1'b0, 1'b0);
        check("dis_fetch", 32'({fetch_x, fetch_y}), 32'd0);
        repeat (20) cycle(1'b1, 1'b0);

        // Randomized enable and swap-request activity.
        r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) r = ~r;
            cycle($urandom_range(0, 15) != 0, r);
        end
        repeat (4) cycle(1'b1, 1'b0);

        // Reset mid-frame with a swap pending and front_sel=1.
        run_to(0, 4, 1'b1, 1'b0);
        cycle(1'b1, !m_front);
        run_to(9, 3, 1'b1, 1'b1);
        check("pre_reset_front", 32'(front_sel), 32'd1);
        do_reset();
        acks = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            cycle(1'b1, 1'b0);
            if (swap_ack) acks++;
        end
        check("no_ack_after_reset", 32'(acks), 32'd0);
        run_to(0, 4, 1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("new_req_ack", 32'(swap_ack), 32'd1);
        repeat (4) cycle(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine: generates raster timing for any mode from parameters, issues pixel fetch coordinates ahead of the beam, and realigns returned pixel data with sync. Arbitrates front/back frame-buffer swaps so a swap only takes effect at the start of vertical blanking. Sits between `VGA_clock` (pixel clock) and the board VGA pins, with `graphics_driver` on the fetch/swap side. Supersedes the fixed-mode controller plus free-running `refresh_clock`.

## Interface
- `H_ACTIVE`, 1440: visible pixels per line
- `H_FP`, 80 / `H_SYNC`, 152 / `H_BP`, 232: horizontal porches and sync width; `H_TOTAL` = sum = 1904
- `V_ACTIVE`, 900: visible lines
- `V_FP`, 1 / `V_SYNC`, 3 / `V_BP`, 28: vertical porches and sync width; `V_TOTAL` = 932
- `HS_POL`, 0 / `VS_POL`, 1: active level of hsync/vsync
- `COLOR_W`, 4: bits per colour channel
- `RD_LAT`, 2: pixel fetch latency in cycles, ≥1
- `clk` in 1: pixel clock
- `rst` in 1: reset; one clock; asynchronous, active-high
- `en` in 1: scan enable
- `fetch_x` out clog2(H_TOTAL): column being fetched
- `fetch_y` out clog2(V_TOTAL): line being fetched
- `fetch_valid` out 1: fetch position is in the active region
- `pix_rgb` in 3*COLOR_W: {R,G,B} for the fetch issued RD_LAT cycles earlier
- `front_sel` out 1: buffer currently scanned out (0 = frame_a)
- `swap_req` in 1: level; producer requests a buffer swap
- `swap_ack` out 1: one-cycle pulse; swap performed
- `frame_start` out 1: one-cycle pulse at fetch position (0,0)
- `vblank` out 1: fetch_y ≥ V_ACTIVE
- `frame_count` out 16: completed frame starts, wraps mod 2^16
- `hsync`, `vsync` out 1: sync outputs
- `red`, `green`, `blue` out COLOR_W: pixel outputs

## Operation
- Counters h, v: h increments each enabled cycle and wraps at H_TOTAL−1 to 0, incrementing v; v wraps at V_TOTAL−1 to 0.
- fetch_x/fetch_y = h/v; fetch_valid = h<H_ACTIVE && v<V_ACTIVE. All are combinational from the counter registers.
- hsync is active (=HS_POL) for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v with the V parameters.
- Output-side sync and blank are taken from an RD_LAT-deep delay line of (hs, vs, de) and then registered.
- red/green/blue are registered: pix_rgb when the delayed de=1, else 0.
- Swap: at the cycle where (h,v)=(0,V_ACTIVE) with swap_req=1, front_sel toggles and swap_ack pulses.
  - A request raised mid-frame stays pending until the next vblank start.
  - A request rising in that exact cycle is accepted.
  - A request held high across frames swaps once per frame.
  - front_sel never changes while v<V_ACTIVE.
- frame_start pulses when (h,v)=(0,0) and en=1; frame_count increments in the same cycle.
- en=0: counters are forced to (0,0) and the delay line is flushed to inactive. frame_start and swap are suppressed. On re-enable the scan restarts at (0,0) with frame_start.

## Timing
- Reset values: h=v=0, hsync=~HS_POL, vsync=~VS_POL, RGB=0, front_sel=0, swap_ack=0, frame_count=0, delay line inactive.
- Reset mid-frame returns all state to these values asynchronously. The first enabled cycle after release is (0,0).
- Latency: the fetch position presented at cycle t produces sync/RGB on the outputs at t+RD_LAT+1. pix_rgb is sampled at t+RD_LAT.
- swap_ack and front_sel change in the same edge. The first visible effect at the pins is RD_LAT+1 cycles later, which is within the blanking interval.
- Widths: counters are clog2(H_TOTAL) and clog2(V_TOTAL) bits. frame_count wraps 0xFFFF→0x0000.

## Structure
- Package `vga_pkg`: a `vga_timing_t` struct (six porch/sync fields plus two polarities) and constants `VGA_1440x900_60` (defaults above) and `VGA_640x480_60` (640/16/96/48, 480/10/2/33, both polarities 0).
- Sub-module `vga_sync_delay`: parametrised-depth shift register for {hs, vs, de} with async reset to inactive values and a synchronous flush.
- A `main` revision instantiates `vga_scanout` and retires `refresh_clock`; `frame_start` replaces the refresh tick.

## Test plan
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), RD_LAT=2, HS_POL=0, VS_POL=1.
1. Hold rst, then release → hsync=1, vsync=0, RGB=0, front_sel=0. frame_start pulses on the first enabled cycle.
2. Free run → hsync period is 14 cycles, low for 2. Its first low appears at the output 3 cycles after fetch_x=10. vsync is high for 14 cycles per 98-cycle frame.
3. Drive pix_rgb = {fetch_x, fetch_y, 4'hA} delayed by 2 → output pixel at column 5, line 2 is {5, 2, A}. RGB=0 outside the active region.
4. Pulse swap_req to 1 at (3,1) and hold it → swap_ack pulses once at (0,4) and front_sel goes to 1. With swap_req still held, the next frame toggles front_sel back to 0.
5. Drop en at (6,2) for 5 cycles → the outputs go inactive within 1 cycle. Re-enable → frame_start fires and fetch is at (0,0).
6. Assert rst at (9,3) with a swap pending → front_sel=0 and frame_count=0 immediately. There is no swap_ack until a new request arrives after reset.
